// File: rtl/freq_meter_pkg.sv
// Shared defaults and helpers for the frequency / period meter.
package freq_meter_pkg;

  localparam int unsigned DEF_CNT_W          = 32'd32;
  localparam int unsigned DEF_PER_W          = 32'd32;
  localparam int unsigned DEF_GATE_CYCLES    = 32'd50000000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd100000000;

  // Increment that sticks at max_value instead of wrapping; callers size-cast
  // the 64-bit result back to their own counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    logic [63:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Brings an asynchronous square wave into the clk domain and flags its
// rising edges; rise is high for one cycle, three clocks after the input edge.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two metastability stages followed by one history stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_async;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// Frequency (edges per gate window) and period (clk cycles between rising
// edges) meter for a single asynchronous square-wave input.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned PER_W          = DEF_PER_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic [PER_W-1:0] period_out,
  output logic             period_valid,
  output logic             no_signal
);

  localparam int unsigned       GATE_W      = (GATE_CYCLES > 32'd1) ? $clog2(GATE_CYCLES) : 32'd1;
  localparam logic [GATE_W-1:0] GATE_LAST   = GATE_W'(GATE_CYCLES - 32'd1);
  localparam logic [GATE_W-1:0] GATE_ONE    = GATE_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [PER_W-1:0]  PER_MAX     = '1;
  localparam logic [PER_W-1:0]  PER_ONE     = PER_W'(32'd1);
  localparam logic [PER_W-1:0]  TIMEOUT_VAL = PER_W'(TIMEOUT_CYCLES);

  logic              rise;
  logic              gate_last;
  logic              edge_sat;
  logic [CNT_W-1:0]  edge_inc;
  logic [PER_W-1:0]  per_inc;

  logic [GATE_W-1:0] gate_cnt_q,     gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q,     edge_cnt_d;
  logic              ovf_win_q,      ovf_win_d;
  logic [PER_W-1:0]  per_cnt_q,      per_cnt_d;
  logic              armed_q,        armed_d;
  logic [CNT_W-1:0]  freq_out_q,     freq_out_d;
  logic              freq_valid_q,   freq_valid_d;
  logic              freq_ovf_q,     freq_ovf_d;
  logic [PER_W-1:0]  period_out_q,   period_out_d;
  logic              period_valid_q, period_valid_d;
  logic              no_signal_q,    no_signal_d;

  edge_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (sig_in),
    .rise    (rise)
  );

  assign gate_last = (gate_cnt_q == GATE_LAST);
  // A rise that finds the counter already full is what marks the window as saturated.
  assign edge_sat  = rise & (edge_cnt_q == CNT_MAX);
  assign edge_inc  = CNT_W'(sat_inc(64'(edge_cnt_q), 64'(CNT_MAX)));
  assign per_inc   = PER_W'(sat_inc(64'(per_cnt_q), 64'(PER_MAX)));

  // Next-state for the gate window, edge counter and period/timeout path.
  always_comb begin
    gate_cnt_d     = gate_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    ovf_win_d      = ovf_win_q;
    per_cnt_d      = per_cnt_q;
    armed_d        = armed_q;
    freq_out_d     = freq_out_q;
    freq_ovf_d     = freq_ovf_q;
    period_out_d   = period_out_q;
    no_signal_d    = no_signal_q;
    freq_valid_d   = 1'b0;
    period_valid_d = 1'b0;

    if (!enable) begin
      // Counters parked at zero; published results keep their last values.
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      ovf_win_d  = 1'b0;
      per_cnt_d  = '0;
      armed_d    = 1'b0;
    end else begin
      if (gate_last) begin
        // A rise on the closing cycle still belongs to this window.
        gate_cnt_d   = '0;
        edge_cnt_d   = '0;
        ovf_win_d    = 1'b0;
        freq_out_d   = rise ? edge_inc : edge_cnt_q;
        freq_ovf_d   = ovf_win_q | edge_sat;
        freq_valid_d = 1'b1;
      end else begin
        gate_cnt_d = gate_cnt_q + GATE_ONE;
        edge_cnt_d = rise ? edge_inc : edge_cnt_q;
        ovf_win_d  = ovf_win_q | edge_sat;
      end

      if (rise) begin
        // Rise wins over a coincident timeout; the first one after idle only arms.
        per_cnt_d   = PER_ONE;
        armed_d     = 1'b1;
        no_signal_d = 1'b0;
        if (armed_q) begin
          period_out_d   = per_cnt_q;
          period_valid_d = 1'b1;
        end else begin
          period_out_d   = period_out_q;
          period_valid_d = 1'b0;
        end
      end else if (per_cnt_q == TIMEOUT_VAL) begin
        per_cnt_d    = per_inc;
        armed_d      = 1'b0;
        no_signal_d  = 1'b1;
        period_out_d = '0;
      end else begin
        per_cnt_d = per_inc;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt_q     <= '0;
      edge_cnt_q     <= '0;
      ovf_win_q      <= 1'b0;
      per_cnt_q      <= '0;
      armed_q        <= 1'b0;
      freq_out_q     <= '0;
      freq_valid_q   <= 1'b0;
      freq_ovf_q     <= 1'b0;
      period_out_q   <= '0;
      period_valid_q <= 1'b0;
      no_signal_q    <= 1'b0;
    end else begin
      gate_cnt_q     <= gate_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      ovf_win_q      <= ovf_win_d;
      per_cnt_q      <= per_cnt_d;
      armed_q        <= armed_d;
      freq_out_q     <= freq_out_d;
      freq_valid_q   <= freq_valid_d;
      freq_ovf_q     <= freq_ovf_d;
      period_out_q   <= period_out_d;
      period_valid_q <= period_valid_d;
      no_signal_q    <= no_signal_d;
    end
  end

  assign freq_out     = freq_out_q;
  assign freq_valid   = freq_valid_q;
  assign freq_ovf     = freq_ovf_q;
  assign period_out   = period_out_q;
  assign period_valid = period_valid_q;
  assign no_signal    = no_signal_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter: one instance with a 1000-cycle
// gate for frequency/period/timeout/enable, one 4-bit instance for overflow.
module tb_freq_meter;

  logic        clk;
  logic        reset;
  logic        enable_a, enable_b;
  logic        sig_a, sig_b;
  logic [31:0] freq_out_a, period_out_a, period_out_b;
  logic [3:0]  freq_out_b;
  logic        freq_valid_a, freq_ovf_a, period_valid_a, no_signal_a;
  logic        freq_valid_b, freq_ovf_b, period_valid_b, no_signal_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_rise_a = 0;
  logic prev_a = 1'b0;
  int hi_a = 0, lo_a = 0, ph_a = 0;
  int hi_b = 0, lo_b = 0, ph_b = 0;
  int n_fv_a = 0, n_pv_a = 0, n_fv_b = 0;
  int w, c0, nf0, np0;

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(32), .PER_W(32), .TIMEOUT_CYCLES(200)) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .sig_in(sig_a),
    .freq_out(freq_out_a), .freq_valid(freq_valid_a), .freq_ovf(freq_ovf_a),
    .period_out(period_out_a), .period_valid(period_valid_a), .no_signal(no_signal_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .PER_W(32), .TIMEOUT_CYCLES(200)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .sig_in(sig_b),
    .freq_out(freq_out_b), .freq_valid(freq_valid_b), .freq_ovf(freq_ovf_b),
    .period_out(period_out_b), .period_valid(period_valid_b), .no_signal(no_signal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    if (sig_a && !prev_a) last_rise_a = cyc;
    prev_a = sig_a;
    @(posedge clk);
    #1;
    cyc++;
    if (freq_valid_a) n_fv_a++;
    if (period_valid_a) n_pv_a++;
    if (freq_valid_b) n_fv_b++;
    if (hi_a > 0) begin
      ph_a++;
      if (sig_a && ph_a >= hi_a) begin sig_a = 1'b0; ph_a = 0; end
      else if (!sig_a && ph_a >= lo_a) begin sig_a = 1'b1; ph_a = 0; end
    end
    if (hi_b > 0) begin
      ph_b++;
      if (sig_b && ph_b >= hi_b) begin sig_b = 1'b0; ph_b = 0; end
      else if (!sig_b && ph_b >= lo_b) begin sig_b = 1'b1; ph_b = 0; end
    end
  endtask

  task automatic wait_fv_a(input int budget, output int waited);
    waited = 0;
    do begin step(); waited++; end while (freq_valid_a !== 1'b1 && waited < budget);
    check("fv_a_arrives", 64'(freq_valid_a), 64'd1);
  endtask

  task automatic wait_pv_a(input int budget, output int waited);
    waited = 0;
    do begin step(); waited++; end while (period_valid_a !== 1'b1 && waited < budget);
    check("pv_a_arrives", 64'(period_valid_a), 64'd1);
  endtask

  task automatic wait_fv_b(input int budget, output int waited);
    waited = 0;
    do begin step(); waited++; end while (freq_valid_b !== 1'b1 && waited < budget);
    check("fv_b_arrives", 64'(freq_valid_b), 64'd1);
  endtask

  initial begin
    reset = 1'b1; enable_a = 1'b1; enable_b = 1'b1;
    sig_a = 1'b0; sig_b = 1'b0;

    // Reset with the input toggling every cycle.
    hi_a = 1; lo_a = 1;
    repeat (3) step();
    check("rst_freq_out",     64'(freq_out_a),     64'd0);
    check("rst_freq_valid",   64'(freq_valid_a),   64'd0);
    check("rst_freq_ovf",     64'(freq_ovf_a),     64'd0);
    check("rst_period_out",   64'(period_out_a),   64'd0);
    check("rst_period_valid", 64'(period_valid_a), 64'd0);
    check("rst_no_signal",    64'(no_signal_a),    64'd0);
    check("rst_freq_out_b",   64'(freq_out_b),     64'd0);
    check("rst_pulses",       64'(n_fv_a + n_pv_a), 64'd0);

    // Frequency: period 10 gives 100 per window; first pulse after a full window.
    hi_a = 5; lo_a = 5; ph_a = 0;
    reset = 1'b0;
    wait_fv_a(1100, w);
    check("first_window_latency", 64'(w), 64'd1000);
    step();
    check("fv_one_cycle", 64'(freq_valid_a), 64'd0);
    wait_fv_a(1100, w);
    check("window_spacing", 64'(w), 64'd999);
    check("freq_p10",       64'(freq_out_a),   64'd100);
    check("ovf_p10",        64'(freq_ovf_a),   64'd0);
    check("period_p10",     64'(period_out_a), 64'd10);

    // Period: rises 37 cycles apart.
    hi_a = 18; lo_a = 19;
    repeat (3) wait_pv_a(100, w);
    check("period_p37", 64'(period_out_a), 64'd37);
    c0 = cyc;
    wait_pv_a(100, w);
    check("period_p37_spacing", 64'(cyc - c0),     64'd37);
    check("period_p37_again",   64'(period_out_a), 64'd37);

    // Timeout: input stops low; no_signal at per_cnt == 200 (rise + 3 + 200).
    hi_a = 0; sig_a = 1'b0;
    w = 0;
    while (no_signal_a !== 1'b1 && w < 400) begin step(); w++; end
    check("timeout_no_signal",  64'(no_signal_a),      64'd1);
    check("timeout_latency",    64'(cyc - last_rise_a), 64'd203);
    check("timeout_period_out", 64'(period_out_a),     64'd0);
    check("timeout_no_pv",      64'(period_valid_a),   64'd0);

    // Recovery: first rise only re-arms, second gives the period.
    np0 = n_pv_a;
    sig_a = 1'b1;
    repeat (10) step();
    check("recover_clear", 64'(no_signal_a),   64'd0);
    check("recover_no_pv", 64'(n_pv_a - np0),  64'd0);
    sig_a = 1'b0;
    repeat (20) step();
    sig_a = 1'b1;
    wait_pv_a(10, w);
    check("recover_pv_latency", 64'(w),            64'd3);
    check("recover_period",     64'(period_out_a), 64'd30);

    // Boundary: 100 rises inside the window plus one on gate count 999.
    sig_a = 1'b0;
    wait_fv_a(1100, w);
    for (int s = 0; s < 1000; s++) begin
      if (s >= 997) sig_a = 1'b1;
      else if (s >= 990) sig_a = (s < 995);
      else sig_a = ((s % 10) < 5);
      step();
    end
    check("boundary_pulse", 64'(freq_valid_a), 64'd1);
    check("boundary_freq",  64'(freq_out_a),   64'd101);
    wait_fv_a(1100, w);
    check("boundary_next_spacing", 64'(w),          64'd1000);
    check("boundary_next_freq",    64'(freq_out_a), 64'd0);

    // Enable: drop mid-window, outputs hold and nothing pulses; re-enable restarts.
    hi_a = 5; lo_a = 5; ph_a = 0;
    repeat (2) wait_fv_a(1100, w);
    check("pre_disable_freq", 64'(freq_out_a), 64'd100);
    repeat (300) step();
    enable_a = 1'b0;
    nf0 = n_fv_a; np0 = n_pv_a;
    repeat (1500) step();
    check("disabled_no_fv",   64'(n_fv_a - nf0), 64'd0);
    check("disabled_no_pv",   64'(n_pv_a - np0), 64'd0);
    check("disabled_freq",    64'(freq_out_a),   64'd100);
    check("disabled_period",  64'(period_out_a), 64'd10);
    check("disabled_nosig",   64'(no_signal_a),  64'd0);
    enable_a = 1'b1;
    c0 = cyc;
    wait_pv_a(30, w);
    check("reenable_first_period", 64'(period_out_a), 64'd10);
    while (freq_valid_a !== 1'b1 && (cyc - c0) < 1100) step();
    check("reenable_window_latency", 64'(cyc - c0),   64'd1000);
    check("reenable_freq",           64'(freq_out_a), 64'd100);

    // Overflow on the 4-bit instance: 25 rises saturate at 15, then 5 rises fit.
    hi_b = 2; lo_b = 2; ph_b = 0;
    repeat (2) wait_fv_b(150, w);
    check("ovf_freq",  64'(freq_out_b), 64'd15);
    check("ovf_flag",  64'(freq_ovf_b), 64'd1);
    hi_b = 10; lo_b = 10; ph_b = 0;
    repeat (2) wait_fv_b(150, w);
    check("slow_freq", 64'(freq_out_b), 64'd5);
    check("slow_flag", 64'(freq_ovf_b), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
